// File: rtl/pc_rx_packet_decoder.sv
// pc_rx_packet_decoder: frames UART bytes into 32-bit RX FIFO words with per-packet integrity status
module pc_rx_packet_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  SYNC_BYTE      = 8'h7E
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [7:0]  i_rx_byte,
    input  logic        i_rx_byte_valid,
    input  logic        i_fifo_full,
    output logic        o_fifo_write_cmd,
    output logic [31:0] o_fifo_write_word,
    output logic [1:0]  o_packet_command,
    output logic        o_packet_start_decode,
    output logic        o_packet_fully_decoded,
    output logic        o_packet_error,
    output logic [1:0]  o_error_code,
    output logic        o_busy
);
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    typedef enum logic [2:0] {IDLE, CMD, COUNT, PAYLOAD, CHECKSUM} state_t;
    state_t        state_q, state_d;
    logic [1:0]    cmd_q, cmd_d;
    logic [7:0]    n_q, n_d, wcnt_q, wcnt_d, x_q, x_d;
    logic [1:0]    bcnt_q, bcnt_d;
    logic [23:0]   asm_q, asm_d;
    logic          ovf_q, ovf_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          wr_q, wr_d, start_q, start_d, done_q, done_d, err_q, err_d, busy_q;
    logic [31:0]   word_q, word_d;
    logic [1:0]    code_q, code_d;
    logic          timeout;
    logic [7:0]    b;
    assign b       = i_rx_byte;
    assign timeout = (state_q != IDLE) && !i_rx_byte_valid && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    // Next-state and registered-output decode; a timeout outranks any state action
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        n_d     = n_q;
        wcnt_d  = wcnt_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        x_d     = x_q;
        ovf_d   = ovf_q;
        tmo_d   = (state_q == IDLE || i_rx_byte_valid || timeout) ? '0 : tmo_q + 1'b1;
        wr_d    = 1'b0;
        word_d  = word_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
        code_d  = code_q;
        if (timeout) begin
            state_d = IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
            code_d  = 2'd3;
        end else if (i_rx_byte_valid) begin
            case (state_q)
                IDLE: if (b == SYNC_BYTE) begin
                    state_d = CMD;
                    wcnt_d  = '0;
                    bcnt_d  = '0;
                    ovf_d   = 1'b0;
                    x_d     = '0;
                end
                CMD: if (b[7:2] != 6'd0 || b[1:0] == 2'd0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    code_d  = 2'd3;
                end else begin
                    state_d = COUNT;
                    cmd_d   = b[1:0];
                    start_d = 1'b1;
                    err_d   = 1'b0;
                    code_d  = 2'd0;
                    x_d     = b;
                end
                COUNT: begin
                    n_d     = b;
                    x_d     = x_q ^ b;
                    state_d = (b == 8'd0) ? CHECKSUM : PAYLOAD;
                end
                PAYLOAD: begin
                    asm_d  = {asm_q[15:0], b};
                    x_d    = x_q ^ b;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        wr_d    = !i_fifo_full;
                        word_d  = i_fifo_full ? word_q : {asm_q, b};
                        ovf_d   = ovf_q | i_fifo_full;
                        wcnt_d  = wcnt_q + 8'd1;
                        state_d = (wcnt_q == n_q - 8'd1) ? CHECKSUM : PAYLOAD;
                    end
                end
                CHECKSUM: begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = ovf_q || (x_q != b);
                    code_d  = ovf_q ? 2'd2 : (x_q != b) ? 2'd1 : 2'd0;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    // State and output registers; reset drops any packet in flight without an end pulse
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            n_q     <= '0;
            wcnt_q  <= '0;
            bcnt_q  <= '0;
            asm_q   <= '0;
            x_q     <= '0;
            ovf_q   <= 1'b0;
            tmo_q   <= '0;
            wr_q    <= 1'b0;
            word_q  <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            n_q     <= n_d;
            wcnt_q  <= wcnt_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            x_q     <= x_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
            wr_q    <= wr_d;
            word_q  <= word_d;
            start_q <= start_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            busy_q  <= (state_d != IDLE);
        end
    end
    assign o_fifo_write_cmd       = wr_q;
    assign o_fifo_write_word      = word_q;
    assign o_packet_command       = cmd_q;
    assign o_packet_start_decode  = start_q;
    assign o_packet_fully_decoded = done_q;
    assign o_packet_error         = err_q;
    assign o_error_code           = code_q;
    assign o_busy                 = busy_q;
endmodule

// File: tb/tb_pc_rx_packet_decoder.sv
// tb_pc_rx_packet_decoder: packet-level reference model checked every cycle, plus directed literal checks
module tb_pc_rx_packet_decoder;
    localparam int         T    = 16;
    localparam logic [7:0] SYNC = 8'h7E;
    logic        clk = 1'b0;
    logic        i_reset = 1'b1, i_rx_byte_valid = 1'b0, i_fifo_full = 1'b0;
    logic [7:0]  i_rx_byte = '0;
    logic        o_fifo_write_cmd, o_packet_start_decode, o_packet_fully_decoded, o_packet_error, o_busy;
    logic [31:0] o_fifo_write_word;
    logic [1:0]  o_packet_command, o_error_code;
    pc_rx_packet_decoder #(.TIMEOUT_CYCLES(T), .SYNC_BYTE(SYNC)) dut (
        .i_clock(clk), .i_reset(i_reset), .i_rx_byte(i_rx_byte), .i_rx_byte_valid(i_rx_byte_valid),
        .i_fifo_full(i_fifo_full), .o_fifo_write_cmd(o_fifo_write_cmd), .o_fifo_write_word(o_fifo_write_word),
        .o_packet_command(o_packet_command), .o_packet_start_decode(o_packet_start_decode),
        .o_packet_fully_decoded(o_packet_fully_decoded), .o_packet_error(o_packet_error),
        .o_error_code(o_error_code), .o_busy(o_busy)
    );
    always #5 clk = ~clk;
    int vectors = 0, miscompares = 0, cyc = 0, last_byte_cyc = 0, done_cyc = 0;
    logic chk_en = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    // expected outputs after the most recent edge
    logic        exp_wr, exp_start, exp_done, exp_err, exp_busy;
    logic [31:0] exp_word;
    logic [1:0]  exp_cmd, exp_code;
    // packet-level parser: position within frame decides the meaning of each byte
    logic        m_in;
    int          m_idx, m_n, m_idle;
    logic [7:0]  m_x;
    logic [31:0] m_acc;
    logic        m_ovf;
    logic [31:0] wlog[$];
    logic [1:0]  slog[$], dlog[$];
    logic [7:0]  pkt[$];
    int          gaps[$];
    logic        fulls[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic finish_pkt(input int code);
        exp_done = 1'b1;
        exp_err  = (code != 0);
        exp_code = code[1:0];
        m_in     = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] b, input logic full, input logic rst);
        exp_wr = 1'b0; exp_start = 1'b0; exp_done = 1'b0;
        if (rst) begin
            exp_word = '0; exp_cmd = '0; exp_err = 1'b0; exp_code = '0; exp_busy = 1'b0;
            m_in = 1'b0; m_idx = 0; m_n = 0; m_idle = 0; m_x = '0; m_acc = '0; m_ovf = 1'b0;
            return;
        end
        if (!m_in) begin
            if (v && b == SYNC) begin
                m_in = 1'b1; m_idx = 1; m_idle = 0; m_ovf = 1'b0; m_x = '0; m_acc = '0;
            end
        end else if (!v) begin
            if (m_idle == T - 1) finish_pkt(3);
            else m_idle++;
        end else begin
            m_idle = 0;
            if (m_idx == 1) begin
                if (b > 8'd3 || b == 8'd0) finish_pkt(3);
                else begin
                    exp_cmd = b[1:0]; exp_start = 1'b1; exp_err = 1'b0; exp_code = 2'd0; m_x = b;
                end
            end else if (m_idx == 2) begin
                m_n = int'(b); m_x ^= b;
            end else if (m_idx < 3 + 4 * m_n) begin
                m_acc = {m_acc[23:0], b}; m_x ^= b;
                if ((m_idx - 3) % 4 == 3) begin
                    if (full) m_ovf = 1'b1;
                    else begin exp_wr = 1'b1; exp_word = m_acc; end
                end
            end else finish_pkt(m_ovf ? 2 : (m_x != b) ? 1 : 0);
            m_idx++;
        end
        exp_busy = m_in;
    endtask

    task automatic tick(input logic v, input logic [7:0] b, input logic full, input logic rst);
        i_reset = rst; i_rx_byte_valid = v; i_rx_byte = b; i_fifo_full = full;
        @(posedge clk);
        #1;
        model_step(v, b, full, rst);
        if (v) last_byte_cyc = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic add(input logic [7:0] b, input int g, input logic f);
        pkt.push_back(b); gaps.push_back(g); fulls.push_back(f);
    endtask

    task automatic send();
        for (int i = 0; i < pkt.size(); i++) begin
            for (int g = 0; g < gaps[i]; g++) tick(1'b0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
            tick(1'b1, pkt[i], fulls[i], 1'b0);
        end
        pkt.delete(); gaps.delete(); fulls.delete();
    endtask

    task automatic clear_logs();
        wlog.delete(); slog.delete(); dlog.delete();
    endtask

    task automatic loopback(input logic [7:0] chk);
        add(SYNC, 0, 0); add(8'h01, 0, 0); add(8'h01, 0, 0);
        add(8'hDE, 0, 0); add(8'hAD, 0, 0); add(8'hBE, 0, 0); add(8'hEF, 0, 0); add(chk, 0, 0);
        send();
    endtask

    // single compare process: every output against the model, plus event logging for directed checks
    always @(negedge clk) begin
        if (chk_en) begin
            check("write_cmd", 32'(o_fifo_write_cmd), 32'(exp_wr));
            check("write_word", o_fifo_write_word, exp_word);
            check("command", 32'(o_packet_command), 32'(exp_cmd));
            check("start_decode", 32'(o_packet_start_decode), 32'(exp_start));
            check("fully_decoded", 32'(o_packet_fully_decoded), 32'(exp_done));
            check("packet_error", 32'(o_packet_error), 32'(exp_err));
            check("error_code", 32'(o_error_code), 32'(exp_code));
            check("busy", 32'(o_busy), 32'(exp_busy));
            if (o_fifo_write_cmd) wlog.push_back(o_fifo_write_word);
            if (o_packet_start_decode) slog.push_back(o_packet_command);
            if (o_packet_fully_decoded) begin dlog.push_back(o_error_code); done_cyc = cyc; end
        end
    end

    initial begin
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        chk_en = 1'b1;
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        idle(2);
        check("reset_busy", 32'(o_busy), 0);
        check("reset_word", o_fifo_write_word, 0);
        check("reset_cmd", 32'(o_packet_command), 0);
        clear_logs(); loopback(8'h22); idle(3);
        check("lb_writes", wlog.size(), 1);
        check("lb_word", wlog[0], 32'hDEADBEEF);
        check("lb_start_cmd", 32'(slog[0]), 1);
        check("lb_code", 32'(dlog[0]), 0);
        clear_logs(); loopback(8'h23); idle(3);
        check("badchk_word", wlog[0], 32'hDEADBEEF);
        check("badchk_code", 32'(dlog[0]), 1);
        check("badchk_err", 32'(o_packet_error), 1);
        clear_logs();
        add(SYNC, 0, 0); add(8'h02, 0, 0); add(8'h02, 0, 0);
        add(8'h11, 0, 0); add(8'h22, 0, 0); add(8'h33, 0, 0); add(8'h44, 0, 0);
        add(8'h55, 0, 1); add(8'h66, 0, 1); add(8'h77, 0, 1); add(8'h88, 0, 1); add(8'h88, 0, 0);
        send(); idle(3);
        check("ovf_writes", wlog.size(), 1);
        check("ovf_word", wlog[0], 32'h11223344);
        check("ovf_code", 32'(dlog[0]), 2);
        clear_logs();
        add(8'h00, 0, 0); add(8'h55, 0, 0); add(SYNC, 0, 0); add(8'h02, 0, 0); add(8'h00, 0, 0); add(8'h02, 0, 0);
        send(); idle(3);
        check("zero_start_cmd", 32'(slog[0]), 2);
        check("zero_writes", wlog.size(), 0);
        check("zero_code", 32'(dlog[0]), 0);
        clear_logs();
        add(SYNC, 0, 0); add(8'h03, 0, 0); add(8'h01, 0, 0); add(8'hAA, 0, 0); add(8'hBB, 0, 0);
        send(); idle(T + 4);
        check("tmo_code", 32'(dlog[0]), 3);
        check("tmo_latency", 32'(done_cyc - last_byte_cyc), 16);
        check("tmo_writes", wlog.size(), 0);
        check("tmo_busy", 32'(o_busy), 0);
        clear_logs();
        add(SYNC, 0, 0); add(8'h04, 0, 0);
        send(); idle(3);
        check("badcmd_code", 32'(dlog[0]), 3);
        check("badcmd_starts", slog.size(), 0);
        clear_logs();
        add(SYNC, 0, 0); add(8'h01, 0, 0); add(8'h01, 0, 0); add(8'hDE, 0, 0); add(8'hAD, 0, 0);
        send();
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        idle(1);
        check("rst_word", o_fifo_write_word, 0);
        check("rst_cmd", 32'(o_packet_command), 0);
        check("rst_no_end", dlog.size(), 0);
        clear_logs(); loopback(8'h22); idle(2);
        check("post_rst_word", wlog[0], 32'hDEADBEEF);
        check("post_rst_code", 32'(dlog[0]), 0);
        for (int p = 0; p < 60; p++) begin
            logic [7:0] cmd, n, x, d;
            logic       lg;
            cmd = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 8)) : 8'($urandom_range(1, 3));
            n   = 8'($urandom_range(0, 3));
            lg  = ($urandom_range(0, 7) == 0);
            x   = cmd ^ n;
            if ($urandom_range(0, 3) == 0) add(8'($urandom_range(0, 125)), $urandom_range(0, 2), 0);
            add(SYNC, $urandom_range(0, 2), 0);
            add(cmd, $urandom_range(0, 2), 0);
            add(n, $urandom_range(0, 2), 0);
            for (int i = 0; i < 4 * int'(n); i++) begin
                d = 8'($urandom_range(0, 255));
                x ^= d;
                add(d, (lg && i == 1) ? 20 : $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
            end
            add(($urandom_range(0, 3) == 0) ? x ^ 8'h01 : x, $urandom_range(0, 1), 0);
            send();
        end
        idle(T + 4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
